// File: rtl/segment_chase_decoder.sv
// segment_chase_decoder: recovers figure-eight chaser head state from segment PWM duty; define SEG_CHASE_DECODER_INVERT_EN for active-low segments
module segment_chase_decoder #(
  parameter int WIN_WIDTH   = 8,
  parameter int FULL_THRESH = 240,
  parameter int LOCK_COUNT  = 3
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam int CW = WIN_WIDTH + 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  logic clk, rst;
  logic [5:0] seg_in, seg, full;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [5:0][CW-1:0] hi_cnt, hi_next;
  logic [2:0] state, cand, seg_state;
  logic [LW-1:0] lock_cnt, lock_next;
  logic dir, strobe, err, prev_valid;
  logic wrap, zero, one_full, multi, has_cand, gap_err, fwd, bwd, step, jump, err_set;
  assign clk = io_in[0];
  assign rst = io_in[1];
`ifdef SEG_CHASE_DECODER_INVERT_EN
  assign seg_in = ~io_in[7:2];
`else
  assign seg_in = io_in[7:2];
`endif
  // per-segment high count including this cycle's sample, saturating, and its full verdict
  always_comb begin
    hi_next = hi_cnt;
    full = '0;
    for (int i = 0; i < 6; i++) begin
      hi_next[i] = &hi_cnt[i] ? hi_cnt[i] : hi_cnt[i] + CW'(seg[i]);
      full[i] = hi_next[i] >= CW'(FULL_THRESH);
    end
  end
  // window-end candidate (g states inferred from the previous state) and step classification
  always_comb begin
    wrap = &win_cnt;
    zero = full == '0;
    multi = |(full & (full - 6'd1));
    one_full = !zero && !multi;
    seg_state = full[0] ? 3'd0 : full[1] ? 3'd1 : full[2] ? 3'd5 : full[3] ? 3'd4 : full[4] ? 3'd3 : 3'd7;
    gap_err = wrap && zero && prev_valid && state[1:0] == 2'b00;
    has_cand = one_full || (zero && prev_valid && state[1:0] != 2'b00);
    cand = one_full ? seg_state : state[0] ? {state[2], 2'b10} : state;
    fwd = cand == state + 3'd1;
    bwd = cand == state - 3'd1;
    step = wrap && has_cand && prev_valid && (fwd || bwd);
    jump = wrap && has_cand && prev_valid && cand != state && !fwd && !bwd;
    err_set = (wrap && multi) || gap_err || jump;
    lock_next = fwd != dir ? LW'(1) : lock_cnt == LW'(LOCK_COUNT) ? lock_cnt : lock_cnt + LW'(1);
  end
  // input register, duty window counters and decoded head state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= '0;
      win_cnt <= '0;
      hi_cnt <= '0;
      state <= '0;
      dir <= 1'b0;
      strobe <= 1'b0;
      err <= 1'b0;
      prev_valid <= 1'b0;
      lock_cnt <= '0;
    end else begin
      seg <= seg_in;
      win_cnt <= win_cnt + WIN_WIDTH'(1);
      hi_cnt <= wrap ? '0 : hi_next;
      strobe <= step;
      if (wrap && has_cand) begin
        state <= cand;
        prev_valid <= 1'b1;
      end
      if (err_set)
        err <= 1'b1;
      if ((wrap && multi) || jump)
        lock_cnt <= '0;
      else if (step) begin
        lock_cnt <= lock_next;
        dir <= fwd;
      end
    end
  end
  assign io_out = {|seg, err, strobe, lock_cnt == LW'(LOCK_COUNT), dir, state};
endmodule

// File: tb/tb_segment_chase_decoder.sv
// tb_segment_chase_decoder: directed windows of segment patterns with hand-computed io_out
module tb_segment_chase_decoder;
  localparam logic [5:0] A = 6'h01, B = 6'h02, C = 6'h04, D = 6'h08, E = 6'h10, F = 6'h20, N = 6'h00;
  localparam logic [5:0] FWD_SEG [9] = '{A, B, N, E, D, C, N, F, A};
  localparam logic [7:0] FWD_E1 [9] = '{8'h80, 8'hA9, 8'h2A, 8'hBB, 8'hBC, 8'hBD, 8'h3E, 8'hBF, 8'hB8};
  localparam logic [7:0] FWD_E2 [9] = '{8'h80, 8'h89, 8'h0A, 8'h9B, 8'h9C, 8'h9D, 8'h1E, 8'h9F, 8'h98};
  localparam logic [5:0] REV_SEG [8] = '{F, N, C, D, E, N, B, A};
  localparam logic [7:0] REV_E1 [8] = '{8'hA7, 8'h26, 8'hB5, 8'hB4, 8'hB3, 8'h32, 8'hB1, 8'hB0};
  localparam logic [7:0] REV_E2 [8] = '{8'h87, 8'h06, 8'h95, 8'h94, 8'h93, 8'h12, 8'h91, 8'h90};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] seg = '0;
  logic [7:0] io_out;
  int passed = 0;
  int total = 0;

  segment_chase_decoder dut (.io_in({seg, rst, clk}), .io_out(io_out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one full duty window: static segments s plus PWM on a (da/256) and b (db/256)
  task automatic win(input string tag, input logic [5:0] s, input int da, input int db, input logic [7:0] exp);
    for (int c = 0; c < 256; c++) begin
      seg = s | {4'b0, 1'(c < db), 1'(c < da)};
      @(posedge clk);
      #1;
      if (c == 254) check({tag, "_prestb"}, {7'b0, io_out[5]}, 8'h00);
    end
    check(tag, io_out, exp);
  endtask

  initial begin
    do_reset();
    check("reset", io_out, 8'h00);
    for (int i = 0; i < 4; i++) win($sformatf("idle%0d", i), N, 0, 0, 8'h00);

    do_reset();
    win("a1", A, 0, 0, 8'h80);
    win("a2", A, 0, 0, 8'h80);
    win("b1", B, 0, 0, 8'hA9);
    win("b2", B, 0, 0, 8'h89);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      win($sformatf("fwd%0d_w1", i), FWD_SEG[i], 0, 0, FWD_E1[i]);
      win($sformatf("fwd%0d_w2", i), FWD_SEG[i], 0, 0, FWD_E2[i]);
    end
    for (int i = 0; i < 8; i++) begin
      win($sformatf("rev%0d_w1", i), REV_SEG[i], 0, 0, REV_E1[i]);
      win($sformatf("rev%0d_w2", i), REV_SEG[i], 0, 0, REV_E2[i]);
    end

    do_reset();
    win("pwm250_1", N, 250, 128, 8'h00);
    win("pwm250_2", N, 250, 128, 8'h00);
    win("pwm239", N, 239, 128, 8'h40);

    do_reset();
    win("thr_a240", N, 240, 0, 8'h00);
    win("thr_b240", N, 0, 240, 8'h29);
    win("thr_b239", N, 0, 239, 8'h2A);

    do_reset();
    win("jmp_a", A, 0, 0, 8'h80);
    win("jmp_d", D, 0, 0, 8'hC4);

    do_reset();
    win("lk_a", A, 0, 0, 8'h80);
    win("lk_b", B, 0, 0, 8'hA9);
    win("lk_g", N, 0, 0, 8'h2A);
    win("lk_e", E, 0, 0, 8'hBB);
    win("two_full", E | D, 0, 0, 8'hCB);
    win("err_hold", E, 0, 0, 8'hCB);
    win("err_step", D, 0, 0, 8'hEC);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_clears", io_out, 8'h00);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/segment_chase_decoder.md
Name: segment_chase_decoder

Overview:
- Observer for the figure-eight segment chaser.
- Samples six outer seven-segment lines (a..f) and measures each line's PWM duty over fixed windows.
- Reconstructs the chaser's 3-bit head state, including the two middle-segment (g) states, which are inferred because g is not observed.
- Reports head state, chase direction, lock status, a step strobe and a sticky error; used on-chip or on a second tile for self-check of the chaser output.

Parameters:
- WIN_WIDTH, 8: duty window length is 2^WIN_WIDTH clocks.
- FULL_THRESH, 240: minimum high-cycle count within one window for a segment to count as "full". Legal range 1..2^WIN_WIDTH.
- LOCK_COUNT, 3: consecutive same-direction valid steps required to assert locked.

Ports:
- io_in[0], input, 1: clk.
- io_in[1], input, 1: reset; synchronous, active-high.
- io_in[7:2], input, 6: segment lines a,b,c,d,e,f on bits 2..7; active-high.
- io_out[2:0], output, 3: decoded head state, 0..7.
- io_out[3], output, 1: direction; 1 = incrementing state.
- io_out[4], output, 1: locked.
- io_out[5], output, 1: step strobe, one clock wide.
- io_out[6], output, 1: sticky error.
- io_out[7], output, 1: activity = OR of registered segment inputs.

Behaviour:
- Clock and reset: one clock, clk = io_in[0]. Reset is synchronous, active-high, reset = io_in[1].
- Reset values: all outputs 0; window counter 0; all duty counters 0; prev-valid flag 0; lock counter 0.
- Input registering: segment inputs are registered once before use; activity output is taken from these registered bits.
- Duty counters:
  - Free-running window counter, WIN_WIDTH bits.
  - Six saturating per-segment high counters, WIN_WIDTH+1 bits.
  - On the cycle the window counter wraps (all ones), each counter's final value, including that cycle's sample, is compared against FULL_THRESH. All counters then clear.
- Segment-to-state mapping: a=0, b=1, e=3, d=4, c=5, f=7. State 2 and state 6 are g.
- Evaluation at each window end, one clock after the window's last cycle:
  - Exactly one segment full: candidate = mapped state.
  - Zero full and prev-valid set: prev 1 or 3 gives candidate 2; prev 5 or 7 gives candidate 6. Prev 2 or 6 gives candidate = prev (hold). Prev 0 or 4 sets error and gives no candidate.
  - Zero full and prev-valid clear: no candidate, no error.
  - Two or more full: no candidate, error set, lock counter cleared, locked cleared.
- Step rules, applied when a candidate exists:
  - Prev-valid clear: state <= candidate; prev-valid set; no strobe.
  - Candidate == state: no change.
  - Candidate == state+1 mod 8: direction 1, strobe.
  - Candidate == state-1 mod 8: direction 0, strobe.
  - Any other candidate: error set, lock counter cleared, state <= candidate, no strobe.
- Lock counter (on each strobe):
  - Increments, saturating at LOCK_COUNT, if the step direction equals the previous step direction; otherwise it is set to 1.
  - locked = (lock counter == LOCK_COUNT).
  - Wrap steps 7->0 and 0->7 count as normal steps.
- Strobe and error:
  - Strobe is high for exactly one clock, in the evaluation cycle.
  - Error clears only on reset.
- Reset mid-window: the partial window is discarded; the next window starts at counter 0.
- Scope limit: correct decoding requires the chaser step period to be at least 2 windows. Faster chasing is flagged through error and is otherwise unspecified.

Optional Feature:
- Macro SEG_CHASE_DECODER_INVERT_EN.
- Defined: the six segment inputs are inverted at the input register, for active-low displays. The activity output follows the inverted (logical) value.
- Undefined: segment inputs are used as-is.

Test Plan:
- Reset, all segments 0 for 4 windows -> io_out = 0x00, no strobe, no error.
- Hold a=1 for 2 windows, then b=1 for 2 windows (all other segments 0) -> state 0 then 1, direction 1, one strobe, locked 0.
- Full forward figure-eight sequence a,b,(none),e,d,c,(none),f,a, 2 windows each -> states 0,1,2,3,4,5,6,7,0. Locked asserts on the 3rd strobe. No error. 7->0 wrap produces a strobe with direction 1.
- Same sequence reversed after lock -> direction 0 and locked 0 on the first reverse step; locked 1 again after 3 reverse strobes.
- PWM a at 250/256 duty with b at 128/256 -> only a counts as full, state 0. Lowering a to 239/256 -> a no longer full.
- Both a and d full in one window -> error 1 and locked 0. Error stays set until reset; reset clears all outputs on the next clock.
